lfsr_rand_arbiter: RTL and testbench
====================================

# lfsr_rand_arbiter

Shares one 16-bit Galois LFSR between `NUM_REQ` random-number consumers in the visualizer, such as particle, sparkle and colour-jitter engines. The block sequences the generator: it loads the seed, runs a warm-up, then serves requests. Each grant carries a fresh, never-repeated-in-sequence word. A round-robin arbiter grants at most one requester per cycle and advances the LFSR only on grants, so sequences are reproducible per seed.

## Interface
- `NUM_REQ`, default 4: number of requesters, 1..16.
- `WARMUP_CYCLES`, default 16: LFSR steps run after reset or seed load before serving. 0 is legal and means no warm-up.
- `DEFAULT_SEED`, default 16'hACE1: LFSR value loaded on reset. Must be nonzero.
- `clk_in`, input, 1: the single clock. All logic is on its rising edge.
- `rst_in`, input, 1: synchronous, active-high reset.
- `seed_in`, input, 16: new seed value.
- `seed_valid_in`, input, 1: 1-cycle pulse that loads `seed_in` and restarts warm-up.
- `req_in`, input, NUM_REQ: level request per requester. It is held until granted.
- `ready_out`, output, 1: high while in SERVE.
- `grant_out`, output, NUM_REQ: one-hot grant, 1-cycle pulse, registered.
- `data_out`, output, 16: random word for the granted requester. Valid only with `valid_out`.
- `valid_out`, output, 1: high for exactly the cycle `grant_out` is nonzero.

## Operation
- LFSR step uses x^16+x^15+x^2+1 in Galois form:
  - n[0]=q[15]
  - n[1]=q[0]^q[15]
  - n[14]=q[13]^q[15]
  - n[i]=q[i-1] for every other bit
- States: WARM, SERVE.
- WARM:
  - The LFSR steps every cycle and a down-counter decrements.
  - The block enters SERVE on the cycle after the counter reaches 0.
  - With WARMUP_CYCLES=0, the block goes straight to SERVE with no steps.
  - `req_in` is ignored.
- SERVE:
  - Any cycle with req_in≠0 selects a winner: the first asserted bit scanning upward, with wrap, from pointer `rr_ptr`.
  - At the next edge: grant_out←onehot(winner), data_out←current LFSR value, valid_out←1, LFSR←step, rr_ptr←(winner+1) mod NUM_REQ.
  - If req_in=0, the block drives valid_out←0 and grant_out←0, and the LFSR holds.
- A requester drops `req_in` in the cycle it sees its grant. If it is still high, it counts as a new request.
- Seed load:
  - `seed_valid_in` in any state overrides requests that cycle.
  - At the edge: LFSR←seed, counter←WARMUP_CYCLES, state←WARM (or SERVE if WARMUP_CYCLES=0), grant_out/valid_out←0.
  - `rr_ptr` is kept.
- Reset values:
  - LFSR=DEFAULT_SEED
  - counter=WARMUP_CYCLES
  - state=WARM (SERVE if WARMUP_CYCLES=0)
  - rr_ptr=0
  - grant_out=0, valid_out=0, data_out=0, ready_out=0 (1 if WARMUP_CYCLES=0)
- Reset mid-warm-up or mid-grant aborts to the reset values on the next edge. No partial grant is issued.
- Simultaneous `rst_in` and `seed_valid_in`: reset wins.

## Timing
- Request-to-grant latency is 1 cycle.
- Throughput is one grant per cycle with back-to-back grants.
- Warm-up latency: `ready_out` rises WARMUP_CYCLES+1 edges after the reset or seed edge, and falls on the edge that loads a seed.
- `data_out` holds its last value when `valid_out`=0.
- `ready_out` is registered and reflects the state.

## Configuration
- `LFSR_ARB_ZERO_GUARD_EN`
  - Defined: a seed of 16'h0000 loads DEFAULT_SEED instead, because all-zero is the LFSR lock-up state.
  - Undefined: the seed is loaded verbatim. A zero seed yields data_out=0 on every grant, and this is the documented behaviour.

## Test plan
- Reset, WARMUP_CYCLES=0, NUM_REQ=4, seed 16'h8000 loaded, req_in=4'b0001 held -> valid grants with data_out 16'h8000, 16'h4003, 16'h8006 on consecutive cycles, grant_out=4'b0001 each.
- req_in=4'b1111 held continuously from rr_ptr=0 -> grant_out sequence 0001, 0010, 0100, 1000, 0001. Never two bits set.
- WARMUP_CYCLES=16 after reset with req_in=4'b1111 -> no grant and ready_out=0 for 16 cycles. First grant on edge 18 carries DEFAULT_SEED stepped 16 times, checked against the bench model.
- seed_valid_in pulse with req_in active in SERVE -> that edge: valid_out=0 and ready_out falls. Warm-up restarts. rr_ptr is preserved on the next grant.
- Seed 16'h0000 -> with LFSR_ARB_ZERO_GUARD_EN the first word is 16'hACE1 (WARMUP_CYCLES=0). Without it, all words are 16'h0000.
- rst_in asserted in the same cycle as a request and a seed pulse -> next edge: all outputs at reset values, no grant, LFSR=DEFAULT_SEED.

Source files
------------

// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: one 16-bit Galois LFSR (x^16+x^15+x^2+1) shared by
// NUM_REQ random-number consumers through a round-robin arbiter.
// After reset or a seed load the LFSR runs WARMUP_CYCLES warm-up steps.
// The block then serves at most one grant per cycle. The LFSR advances
// only on grants, so each seed gives a reproducible sequence.
//
// Ports:
//   clk_in        - clock, rising edge
//   rst_in        - synchronous active-high reset
//   seed_in       - seed value, loaded when seed_valid_in is high
//   seed_valid_in - 1-cycle pulse: load seed, restart warm-up
//   req_in        - level request per requester, held until granted
//   ready_out     - high while serving (registered state)
//   grant_out     - one-hot grant pulse, registered
//   data_out      - random word for the granted requester
//   valid_out     - high in the cycle grant_out is nonzero
//
// Optional feature macro: LFSR_ARB_ZERO_GUARD_EN
//   When defined, a zero seed is replaced by DEFAULT_SEED. All-zero is the
//   lock-up state of the LFSR.
module lfsr_rand_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter logic [15:0] DEFAULT_SEED  = 16'hACE1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [15:0]        seed_in,
  input  logic               seed_valid_in,
  input  logic [NUM_REQ-1:0] req_in,
  output logic               ready_out,
  output logic [NUM_REQ-1:0] grant_out,
  output logic [15:0]        data_out,
  output logic               valid_out
);

  typedef enum logic {WARM, SERVE} state_t;

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP_CYCLES);
  localparam state_t START_STATE = (WARMUP_CYCLES == 0) ? SERVE : WARM;

  state_t             state, state_n;
  logic [15:0]        lfsr, lfsr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [15:0]        data_n;
  logic               valid_n;
  logic               found;
  logic [PTR_W-1:0]   win, idx;
  logic [15:0]        seed_eff;

  // Galois step: feedback bit q[15] is injected at taps 0, 1 and 14.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    logic [15:0] n;
    n     = {q[14:0], q[15]};
    n[1]  = q[0] ^ q[15];
    n[14] = q[13] ^ q[15];
    return n;
  endfunction

  // Seed actually loaded into the LFSR.
  always_comb begin
`ifdef LFSR_ARB_ZERO_GUARD_EN
    seed_eff = (seed_in == 16'h0000) ? DEFAULT_SEED : seed_in;
`else
    seed_eff = seed_in;
`endif
  end

  // Round-robin pick: the first asserted request scanning upward from rr_ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_in[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_n  = state;
    lfsr_n   = lfsr;
    cnt_n    = cnt;
    rr_ptr_n = rr_ptr;
    grant_n  = '0;
    data_n   = data_out;
    valid_n  = 1'b0;
    if (seed_valid_in) begin
      lfsr_n  = seed_eff;
      cnt_n   = CNT_INIT;
      state_n = START_STATE;
    end else begin
      unique case (state)
        WARM: begin
          if (cnt == '0) begin
            state_n = SERVE;
          end else begin
            lfsr_n = lfsr_step(lfsr);
            cnt_n  = cnt - CNT_W'(1);
          end
        end
        SERVE: begin
          if (found) begin
            grant_n  = NUM_REQ'(1) << win;
            data_n   = lfsr;
            valid_n  = 1'b1;
            lfsr_n   = lfsr_step(lfsr);
            rr_ptr_n = PTR_W'((32'(win) + 1) % NUM_REQ);
          end
        end
        default: state_n = START_STATE;
      endcase
    end
  end

  // State register; ready_out mirrors the registered state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= START_STATE;
      lfsr      <= DEFAULT_SEED;
      cnt       <= CNT_INIT;
      rr_ptr    <= '0;
      grant_out <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      ready_out <= (START_STATE == SERVE);
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      cnt       <= cnt_n;
      rr_ptr    <= rr_ptr_n;
      grant_out <= grant_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      ready_out <= (state_n == SERVE);
    end
  end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Directed testbench for lfsr_rand_arbiter. It uses two instances: one with
// no warm-up (dut0) and one with a 16-step warm-up (dut1).
module tb_lfsr_rand_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst0 = 1'b1, sv0 = 1'b0;
  logic [15:0] seed0 = 16'h0;
  logic [3:0]  req0 = 4'b0;
  logic        ready0, valid0;
  logic [3:0]  grant0;
  logic [15:0] data0;

  logic        rst1 = 1'b1, sv1 = 1'b0;
  logic [15:0] seed1 = 16'h0;
  logic [3:0]  req1 = 4'b0;
  logic        ready1, valid1;
  logic [3:0]  grant1;
  logic [15:0] data1;

  lfsr_rand_arbiter #(.NUM_REQ(4), .WARMUP_CYCLES(0), .DEFAULT_SEED(16'hACE1)) dut0 (
    .clk_in(clk), .rst_in(rst0), .seed_in(seed0), .seed_valid_in(sv0), .req_in(req0),
    .ready_out(ready0), .grant_out(grant0), .data_out(data0), .valid_out(valid0));

  lfsr_rand_arbiter #(.NUM_REQ(4), .WARMUP_CYCLES(16), .DEFAULT_SEED(16'hACE1)) dut1 (
    .clk_in(clk), .rst_in(rst1), .seed_in(seed1), .seed_valid_in(sv1), .req_in(req1),
    .ready_out(ready1), .grant_out(grant1), .data_out(data1), .valid_out(valid1));

  // Reference LFSR step, bit by bit from the polynomial definition.
  function automatic logic [15:0] model_step(input logic [15:0] q);
    logic [15:0] n;
    n[0] = q[15];
    for (int i = 1; i < 16; i++) n[i] = q[i-1];
    n[1]  = q[0] ^ q[15];
    n[14] = q[13] ^ q[15];
    return n;
  endfunction

  function automatic logic [15:0] model_steps(input logic [15:0] q, input int k);
    logic [15:0] r;
    r = q;
    for (int i = 0; i < k; i++) r = model_step(r);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst0 = 1'b1; req0 = 4'b1111;
    rst1 = 1'b1; req1 = 4'b1111;
    tick; tick;
    n_checks++;
    if (grant0 !== 4'b0 || valid0 !== 1'b0 || data0 !== 16'h0 || ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_w0: grant=%b valid=%b data=%h ready=%b, want 0000 0 0000 1",
               grant0, valid0, data0, ready0);
    end
    n_checks++;
    if (grant1 !== 4'b0 || valid1 !== 1'b0 || data1 !== 16'h0 || ready1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_w16: grant=%b valid=%b data=%h ready=%b, want 0000 0 0000 0",
               grant1, valid1, data1, ready1);
    end
    req0 = 4'b0;
  endtask

  task automatic test_single_seed;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h8000; exp_d[1] = 16'h4003; exp_d[2] = 16'h8006;
    rst0 = 1'b1; tick; rst0 = 1'b0;
    seed0 = 16'h8000; sv0 = 1'b1; req0 = 4'b0001;
    tick;
    sv0 = 1'b0;
    n_checks++;
    if (valid0 !== 1'b0 || grant0 !== 4'b0 || ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_edge_w0: valid=%b grant=%b ready=%b, want 0 0000 1", valid0, grant0, ready0);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++;
      if (valid0 !== 1'b1 || grant0 !== 4'b0001 || data0 !== exp_d[k]) begin
        n_fail++;
        $display("FAIL single_grant%0d: valid=%b grant=%b data=%h, want 1 0001 %h",
                 k, valid0, grant0, data0, exp_d[k]);
      end
    end
    req0 = 4'b0;
  endtask

  task automatic test_round_robin;
    logic [3:0]  exp_g [5];
    logic [15:0] d;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    rst0 = 1'b1; req0 = 4'b1111; tick; rst0 = 1'b0;
    d = 16'hACE1;
    for (int k = 0; k < 5; k++) begin
      tick;
      n_checks++;
      if (valid0 !== 1'b1 || grant0 !== exp_g[k] || data0 !== d) begin
        n_fail++;
        $display("FAIL rr_grant%0d: valid=%b grant=%b data=%h, want 1 %b %h",
                 k, valid0, grant0, data0, exp_g[k], d);
      end
      d = model_step(d);
    end
    req0 = 4'b0;
  endtask

  task automatic test_zero_seed;
    logic [15:0] exp_d [2];
`ifdef LFSR_ARB_ZERO_GUARD_EN
    exp_d[0] = 16'hACE1; exp_d[1] = model_step(16'hACE1);
`else
    exp_d[0] = 16'h0000; exp_d[1] = 16'h0000;
`endif
    seed0 = 16'h0000; sv0 = 1'b1; req0 = 4'b0001;
    tick;
    sv0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick;
      n_checks++;
      if (valid0 !== 1'b1 || data0 !== exp_d[k]) begin
        n_fail++;
        $display("FAIL zero_seed%0d: valid=%b data=%h, want 1 %h", k, valid0, data0, exp_d[k]);
      end
    end
    req0 = 4'b0;
    tick;
    n_checks++;
    if (valid0 !== 1'b0 || grant0 !== 4'b0 || data0 !== exp_d[1]) begin
      n_fail++;
      $display("FAIL idle_hold: valid=%b grant=%b data=%h, want 0 0000 %h",
               valid0, grant0, data0, exp_d[1]);
    end
  endtask

  task automatic test_reset_priority;
    rst0 = 1'b1; tick; rst0 = 1'b0;
    req0 = 4'b1111;
    tick;
    tick;
    rst0 = 1'b1; sv0 = 1'b1; seed0 = 16'h5555;
    tick;
    n_checks++;
    if (grant0 !== 4'b0 || valid0 !== 1'b0 || data0 !== 16'h0 || ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_priority: grant=%b valid=%b data=%h ready=%b, want 0000 0 0000 1",
               grant0, valid0, data0, ready0);
    end
    rst0 = 1'b0; sv0 = 1'b0;
    tick;
    n_checks++;
    if (valid0 !== 1'b1 || grant0 !== 4'b0001 || data0 !== 16'hACE1) begin
      n_fail++;
      $display("FAIL rst_then_grant: valid=%b grant=%b data=%h, want 1 0001 ace1",
               valid0, grant0, data0);
    end
    req0 = 4'b0;
  endtask

  task automatic test_warmup_and_reload;
    logic [15:0] d17;
    int bad_ready, bad_valid;
    rst1 = 1'b1; req1 = 4'b1111; tick; rst1 = 1'b0;
    bad_ready = 0; bad_valid = 0;
    for (int e = 1; e <= 17; e++) begin
      tick;
      if (ready1 !== (e == 17)) bad_ready++;
      if (valid1 !== 1'b0 || grant1 !== 4'b0) bad_valid++;
    end
    n_checks++;
    if (bad_ready != 0 || bad_valid != 0) begin
      n_fail++;
      $display("FAIL warmup_quiet: bad ready cycles=%0d bad grant cycles=%0d, want 0 0", bad_ready, bad_valid);
    end
    tick;
    n_checks++;
    if (valid1 !== 1'b1 || grant1 !== 4'b0001 || data1 !== model_steps(16'hACE1, 16)) begin
      n_fail++;
      $display("FAIL warmup_first: valid=%b grant=%b data=%h, want 1 0001 %h",
               valid1, grant1, data1, model_steps(16'hACE1, 16));
    end
    tick;
    d17 = model_steps(16'hACE1, 17);
    n_checks++;
    if (valid1 !== 1'b1 || grant1 !== 4'b0010 || data1 !== d17) begin
      n_fail++;
      $display("FAIL warmup_second: valid=%b grant=%b data=%h, want 1 0010 %h", valid1, grant1, data1, d17);
    end
    seed1 = 16'h1234; sv1 = 1'b1;
    tick;
    sv1 = 1'b0;
    n_checks++;
    if (valid1 !== 1'b0 || grant1 !== 4'b0 || ready1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_edge: valid=%b grant=%b ready=%b, want 0 0000 0", valid1, grant1, ready1);
    end
    bad_ready = 0; bad_valid = 0;
    for (int e = 1; e <= 17; e++) begin
      tick;
      if (ready1 !== (e == 17)) bad_ready++;
      if (valid1 !== 1'b0 || grant1 !== 4'b0) bad_valid++;
    end
    n_checks++;
    if (bad_ready != 0 || bad_valid != 0 || data1 !== d17) begin
      n_fail++;
      $display("FAIL reload_warmup: bad ready=%0d bad grant=%0d data=%h, want 0 0 %h",
               bad_ready, bad_valid, data1, d17);
    end
    tick;
    n_checks++;
    if (valid1 !== 1'b1 || grant1 !== 4'b0100 || data1 !== model_steps(16'h1234, 16)) begin
      n_fail++;
      $display("FAIL reload_grant: valid=%b grant=%b data=%h, want 1 0100 %h",
               valid1, grant1, data1, model_steps(16'h1234, 16));
    end
    req1 = 4'b0;
  endtask

  initial begin
    test_reset;
    test_single_seed;
    test_round_robin;
    test_zero_seed;
    test_reset_priority;
    test_warmup_and_reload;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
